// File: rtl/mem_moc_responder_pkg.sv
// Shared constants, FSM state encoding and alignment helpers for the MOV/MOC memory responder.
package mem_moc_responder_pkg;

   localparam logic [1:0] TYPE_BYTE = 2'b00;
   localparam logic [1:0] TYPE_HALF = 2'b01;
   localparam logic [1:0] TYPE_WORD = 2'b10;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   // Reserved type 2'b11 behaves as a word access.
   function automatic logic is_misaligned(input logic [1:0] typ, input logic [1:0] lo);
      case (typ)
         TYPE_BYTE: is_misaligned = 1'b0;
         TYPE_HALF: is_misaligned = lo[0];
         default:   is_misaligned = (lo != 2'b00);
      endcase
   endfunction

   function automatic logic [1:0] align_lo(input logic [1:0] typ, input logic [1:0] lo);
      case (typ)
         TYPE_BYTE: align_lo = lo;
         TYPE_HALF: align_lo = {lo[1], 1'b0};
         default:   align_lo = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_moc_responder_lane_steer.sv
// mem_lane_steer: big-endian byte-lane steering; lane i is the RAM byte at base address + i.
module mem_lane_steer
   import mem_moc_responder_pkg::*;
(
   input  logic [1:0]      typ,
   input  logic [3:0][7:0] rd_bytes,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic [3:0]      wr_be,
   output logic [3:0][7:0] wr_bytes
);

   // Right-justify reads and spread right-justified store data across lanes.
   always_comb begin
      rdata    = 32'h0000_0000;
      wr_be    = 4'b0000;
      wr_bytes = '0;
      case (typ)
         TYPE_BYTE: begin
            rdata       = {24'h00_0000, rd_bytes[0]};
            wr_be       = 4'b0001;
            wr_bytes[0] = wdata[7:0];
         end
         TYPE_HALF: begin
            rdata       = {16'h0000, rd_bytes[0], rd_bytes[1]};
            wr_be       = 4'b0011;
            wr_bytes[0] = wdata[15:8];
            wr_bytes[1] = wdata[7:0];
         end
         default: begin
            rdata       = {rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]};
            wr_be       = 4'b1111;
            wr_bytes[0] = wdata[31:24];
            wr_bytes[1] = wdata[23:16];
            wr_bytes[2] = wdata[15:8];
            wr_bytes[3] = wdata[7:0];
         end
      endcase
   end

endmodule

// File: rtl/mem_moc_responder.sv
// Memory-side MOV/MOC responder with an internal big-endian byte RAM.
// Define MISALIGN_TRAP_EN to trap misaligned accesses on ALIGN_ERR instead of forcing alignment.
module mem_moc_responder
   import mem_moc_responder_pkg::*;
#(
   parameter int ADDR_W      = 9,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Clr,
   input  logic        MOV,
   input  logic        RW,
   input  logic [1:0]  Type,
   input  logic [31:0] Address,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
`ifdef MISALIGN_TRAP_EN
   output logic        ALIGN_ERR,
`endif
   output logic        MOC
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rw_q, rw_d;
   logic [1:0]          typ_q, typ_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         din_q, din_d;
   logic [31:0]         dout_q, dout_d;
   logic                moc_q, moc_d;
   logic                err_q, err_d;
   logic [7:0]          mem_q [DEPTH];

   logic [ADDR_W-1:0]   base_s;
   logic [3:0][7:0]     rd_bytes_s;
   logic [3:0][7:0]     wr_bytes_s;
   logic [3:0]          wr_be_s;
   logic [31:0]         rdata_s;
   logic                mis_s;
   logic                we_s;

   assign base_s = {addr_q[ADDR_W-1:2], align_lo(typ_q, addr_q[1:0])};

`ifdef MISALIGN_TRAP_EN
   assign mis_s     = is_misaligned(typ_q, addr_q[1:0]);
   assign ALIGN_ERR = err_q;
   logic  unused_s;
   assign unused_s  = ^Address[31:ADDR_W];
`else
   assign mis_s    = 1'b0;
   logic  unused_s;
   assign unused_s = ^{Address[31:ADDR_W], err_q};
`endif

   // Gather the four consecutive bytes starting at the aligned base (wrapping at the top).
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         rd_bytes_s[i] = mem_q[base_s + ADDR_W'(i)];
      end
   end

   mem_lane_steer u_lane_steer (
      .typ      (typ_q),
      .rd_bytes (rd_bytes_s),
      .wdata    (din_q),
      .rdata    (rdata_s),
      .wr_be    (wr_be_s),
      .wr_bytes (wr_bytes_s)
   );

   // Handshake FSM: accept, count down the wait, complete, then hold MOC until MOV drops.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      typ_d   = typ_q;
      addr_d  = addr_q;
      din_d   = din_q;
      dout_d  = dout_q;
      moc_d   = moc_q;
      err_d   = err_q;
      we_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (MOV) begin
               rw_d    = RW;
               typ_d   = Type;
               addr_d  = Address[ADDR_W-1:0];
               din_d   = DataIn;
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (!MOV) begin
               state_d = IDLE;
            end else if (cnt_q != {CNT_W{1'b0}}) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               moc_d   = 1'b1;
               state_d = DONE;
               if (mis_s) begin
                  err_d = 1'b1;
               end else if (rw_q == RW_READ) begin
                  dout_d = rdata_s;
               end else begin
                  we_s = 1'b1;
               end
            end
         end
         DONE: begin
            if (!MOV) begin
               moc_d   = 1'b0;
               err_d   = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            moc_d   = 1'b0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_q <= IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         rw_q    <= RW_READ;
         typ_q   <= TYPE_BYTE;
         addr_q  <= {ADDR_W{1'b0}};
         din_q   <= 32'h0000_0000;
         dout_q  <= 32'h0000_0000;
         moc_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         typ_q   <= typ_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         dout_q  <= dout_d;
         moc_q   <= moc_d;
         err_q   <= err_d;
      end
   end

   // RAM array is deliberately not reset; writes land only on the completion edge.
   always_ff @(posedge Clk) begin
      if (we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be_s[i]) begin
               mem_q[base_s + ADDR_W'(i)] <= wr_bytes_s[i];
            end
         end
      end
   end

   assign DataOut = dout_q;
   assign MOC     = moc_q;

endmodule

// File: tb/tb_mem_moc_responder.sv
// Randomized self-checking bench: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 responder against a transaction-level model.
module tb_mem_moc_responder;

   logic        Clk = 1'b0;
   logic        Clr = 1'b1;
   logic        mov_s  [2];
   logic        rw_s   [2];
   logic [1:0]  typ_s  [2];
   logic [31:0] addr_s [2];
   logic [31:0] din_s  [2];
   logic [31:0] dout_s [2];
   logic        moc_s  [2];
`ifdef MISALIGN_TRAP_EN
   logic        aerr_s [2];
`endif

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  mm       [2][512];
   logic [31:0] exp_dout [2];
   logic        exp_moc  [2];
   logic        exp_err  [2];

   always #5 Clk = ~Clk;

   mem_moc_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) u_w2 (
      .Clk(Clk), .Clr(Clr), .MOV(mov_s[0]), .RW(rw_s[0]), .Type(typ_s[0]),
      .Address(addr_s[0]), .DataIn(din_s[0]), .DataOut(dout_s[0]),
`ifdef MISALIGN_TRAP_EN
      .ALIGN_ERR(aerr_s[0]),
`endif
      .MOC(moc_s[0])
   );

   mem_moc_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) u_w0 (
      .Clk(Clk), .Clr(Clr), .MOV(mov_s[1]), .RW(rw_s[1]), .Type(typ_s[1]),
      .Address(addr_s[1]), .DataIn(din_s[1]), .DataOut(dout_s[1]),
`ifdef MISALIGN_TRAP_EN
      .ALIGN_ERR(aerr_s[1]),
`endif
      .MOC(moc_s[1])
   );

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d actual=%h expected=%h", nm, d, act, exp);
      end
   endtask

   function automatic int wait_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   // Transaction-level effect of a completed access on the model.
   task automatic model_complete(input int d, input logic rw, input logic [1:0] typ,
                                 input logic [31:0] a, input logic [31:0] data);
      int          n;
      int          base;
      logic [31:0] v;
      n    = (typ == 2'b00) ? 1 : ((typ == 2'b01) ? 2 : 4);
      base = int'(a % 32'd512);
      exp_moc[d] = 1'b1;
`ifdef MISALIGN_TRAP_EN
      if ((base % n) != 0) begin
         exp_err[d] = 1'b1;
         return;
      end
`endif
      base = base - (base % n);
      if (rw) begin
         v = 32'h0;
         for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, mm[d][base + i]};
         exp_dout[d] = v;
      end else begin
         for (int i = 0; i < n; i++) mm[d][base + i] = 8'(data >> (8 * (n - 1 - i)));
      end
   endtask

   // One MOV/MOC transaction; inputs are scribbled after accept; abort_at=k drops MOV before edge k.
   task automatic do_op(input int d, input logic rw, input logic [1:0] typ, input logic [31:0] a,
                        input logic [31:0] data, input int hold, input int abort_at, output int lat);
      int w;
      w   = wait_of(d);
      lat = 0;
      @(negedge Clk);
      mov_s[d] = 1'b1; rw_s[d] = rw; typ_s[d] = typ; addr_s[d] = a; din_s[d] = data;
      @(posedge Clk);
      for (int k = 1; k <= w + 1; k++) begin
         @(negedge Clk);
         rw_s[d] = 1'($urandom); typ_s[d] = 2'($urandom); addr_s[d] = $urandom; din_s[d] = $urandom;
         if (k == abort_at) begin
            mov_s[d] = 1'b0;
            @(posedge Clk);
            #1;
            return;
         end
         @(posedge Clk);
         if (k == w + 1) model_complete(d, rw, typ, a, data);
         #1;
         if (moc_s[d] && lat == 0) lat = k;
      end
      repeat (hold) @(negedge Clk);
      @(negedge Clk);
      mov_s[d] = 1'b0;
      @(posedge Clk);
      exp_moc[d] = 1'b0;
      exp_err[d] = 1'b0;
      #1;
   endtask

   // Every-cycle comparison of both responders against the model.
   always @(negedge Clk) begin
      for (int d = 0; d < 2; d++) begin
         chk("moc", d, {31'h0, moc_s[d]}, {31'h0, exp_moc[d]});
         chk("dataout", d, dout_s[d], exp_dout[d]);
`ifdef MISALIGN_TRAP_EN
         chk("align_err", d, {31'h0, aerr_s[d]}, {31'h0, exp_err[d]});
`endif
      end
   end

   initial begin
      int lat;
      int d, w, ab;
      for (int i = 0; i < 2; i++) begin
         mov_s[i] = 1'b0; rw_s[i] = 1'b1; typ_s[i] = 2'b00; addr_s[i] = 32'h0; din_s[i] = 32'h0;
         exp_dout[i] = 32'h0; exp_moc[i] = 1'b0; exp_err[i] = 1'b0;
      end
      #1 Clr = 1'b0;
      repeat (2) @(negedge Clk);
      #1 Clr = 1'b1;

      // Known RAM contents (even words, so never 0xDEADBEEF)
      for (int i = 0; i < 2; i++)
         for (int a = 0; a < 512; a += 4)
            do_op(i, 1'b0, 2'b10, 32'(a), $urandom & 32'hFFFF_FFFE, 0, 0, lat);

      do_op(0, 1'b0, 2'b10, 32'h20, 32'h1234_5678, 0, 0, lat);
      chk("latency_w2", 0, 32'(lat), 32'd3);
      do_op(0, 1'b1, 2'b10, 32'h20, 32'h0, 0, 0, lat);
      chk("word_rd", 0, dout_s[0], 32'h1234_5678);
      do_op(0, 1'b1, 2'b00, 32'h21, 32'h0, 0, 0, lat);
      chk("byte_rd", 0, dout_s[0], 32'h0000_0034);
      do_op(0, 1'b1, 2'b01, 32'h22, 32'h0, 5, 0, lat);
      chk("half_rd_hold", 0, dout_s[0], 32'h0000_5678);
      do_op(0, 1'b0, 2'b00, 32'h23, 32'hFFFF_FFAB, 0, 0, lat);
      do_op(0, 1'b1, 2'b10, 32'h20, 32'h0, 0, 0, lat);
      chk("byte_store", 0, dout_s[0], 32'h1234_56AB);
      do_op(0, 1'b0, 2'b10, 32'h20, 32'hFFFF_FFFF, 0, 1, lat);
      do_op(0, 1'b1, 2'b10, 32'h20, 32'h0, 0, 0, lat);
      chk("abort_no_write", 0, dout_s[0], 32'h1234_56AB);
      do_op(0, 1'b1, 2'b10, 32'h21, 32'h0, 0, 0, lat);
      chk("misalign_word_rd", 0, dout_s[0], 32'h1234_56AB);
      do_op(0, 1'b0, 2'b01, 32'h21, 32'h0000_CAFE, 0, 0, lat);
      do_op(0, 1'b1, 2'b10, 32'h20, 32'h0, 0, 0, lat);
`ifdef MISALIGN_TRAP_EN
      chk("misalign_half_wr", 0, dout_s[0], 32'h1234_56AB);
`else
      chk("misalign_half_wr", 0, dout_s[0], 32'hCAFE_56AB);
`endif

      do_op(1, 1'b0, 2'b10, 32'h20, 32'h1234_5678, 0, 0, lat);
      chk("latency_w0", 1, 32'(lat), 32'd1);
      do_op(1, 1'b1, 2'b10, 32'h0000_0220, 32'h0, 0, 0, lat);
      chk("wrap_rd", 1, dout_s[1], 32'h1234_5678);

      // Reset in the middle of a pending word write
      @(negedge Clk);
      mov_s[0] = 1'b1; rw_s[0] = 1'b0; typ_s[0] = 2'b10; addr_s[0] = 32'h10; din_s[0] = 32'hDEAD_BEEF;
      @(posedge Clk);
      @(posedge Clk);
      #2 Clr = 1'b0;
      mov_s[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_moc[i] = 1'b0; exp_dout[i] = 32'h0; exp_err[i] = 1'b0;
      end
      #1;
      chk("rst_moc", 0, {31'h0, moc_s[0]}, 32'h0);
      chk("rst_dout", 0, dout_s[0], 32'h0);
      @(negedge Clk);
      #1 Clr = 1'b1;
      do_op(0, 1'b1, 2'b10, 32'h10, 32'h0, 0, 0, lat);
      chk("rst_no_commit", 0, {31'h0, dout_s[0] == 32'hDEAD_BEEF}, 32'h0);

      for (int n = 0; n < 300; n++) begin
         d  = int'($urandom_range(0, 1));
         w  = wait_of(d);
         ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, w + 1)) : 0;
         do_op(d, 1'($urandom), 2'($urandom), $urandom, $urandom, int'($urandom_range(0, 2)), ab, lat);
      end

      repeat (2) @(negedge Clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
